mod_updown_counter: RTL and testbench



---
 rtl/mod_updown_counter_pkg.sv | 46 ++++
 rtl/mod_updown_counter.sv | 74 +++++++
 tb/tb_mod_updown_counter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and the pure next-count function for the up/down counter.
// The function works on a fixed 32-bit datapath so any WIDTH up to 32 can reuse it.
package mod_updown_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic             ovf;
        logic             udf;
    } count_result_t;

    // Values above max are never presented, so "not below max" means "at max".
    function automatic count_result_t next_count(
        input logic [CNT_W-1:0] q,
        input logic             dir,
        input logic             mode,
        input logic [CNT_W-1:0] max
    );
        count_result_t res;
        res       = '0;
        res.value = q;
        if (dir == DIR_UP) begin
            if (q < max) begin
                res.value = q + 32'd1;
            end else if (mode == MODE_WRAP) begin
                res.value = '0;
                res.ovf   = 1'b1;
            end
        end else begin
            if (q != '0) begin
                res.value = q - 32'd1;
            end else if (mode == MODE_WRAP) begin
                res.value = max;
                res.udf   = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter modulo MAX_VAL+1 with wrap/saturate mode,
// clear, clamped parallel load, cascade terminal count and wrap pulses.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_udf;

    logic [CNT_W-1:0] w_q_ext;
    count_result_t    w_next;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_load_q;
    logic             w_unused_bits;

    assign w_q_ext  = CNT_W'(r_q);
    assign w_next   = next_count(w_q_ext, dir, mode, CNT_W'(MAX_Q));
    assign w_next_q = w_next.value[WIDTH-1:0];
    assign w_unused_bits = &{1'b0, w_next.value};

    // Out-of-range load values clamp so Q can never leave 0..MAX_VAL.
    assign w_load_q = (load_val > MAX_Q) ? MAX_Q : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= RST_Q;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (clr) begin
            r_q   <= RST_Q;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (en) begin
            r_q   <= w_next_q;
            r_ovf <= w_next.ovf;
            r_udf <= w_next.udf;
        end else begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end
    end

    // Combinational so a downstream stage on the same clock can use it as enable.
    assign tc  = en & ((dir & (r_q == MAX_Q)) | (~dir & (r_q == '0)));
    assign Q   = r_q;
    assign ovf = r_ovf;
    assign udf = r_udf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench: a WIDTH=3/MAX_VAL=5 counter plus a two-stage
// cascade of default counters chained through tc.
module tb_mod_updown_counter;

    logic       clk;
    logic       reset, en, dir, mode, clr, load;
    logic [2:0] loadVal;
    logic [2:0] q;
    logic       tc, ovf, udf;

    logic       cReset, cEn;
    logic [2:0] q0, q1;
    logic       tc0, tc1, ovf0, ovf1, udf0, udf1;

    int checks = 0;
    int errors = 0;

    mod_updown_counter #(.WIDTH(3), .MAX_VAL(5), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .clr(clr), .load(load), .load_val(loadVal),
        .Q(q), .tc(tc), .ovf(ovf), .udf(udf)
    );

    mod_updown_counter stage0 (
        .clk(clk), .reset(cReset), .en(cEn), .dir(1'b1), .mode(1'b0),
        .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .Q(q0), .tc(tc0), .ovf(ovf0), .udf(udf0)
    );

    mod_updown_counter stage1 (
        .clk(clk), .reset(cReset), .en(tc0), .dir(1'b1), .mode(1'b0),
        .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .Q(q1), .tc(tc1), .ovf(ovf1), .udf(udf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cReset = 1'b1; cEn = 1'b0;
        en = 1'b0; dir = 1'b1; mode = 1'b0; clr = 1'b0; load = 1'b0; loadVal = 3'd0;
        tick();
        tick();
        checks++;
        if ({q, ovf, udf} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got q=%0d ovf=%b udf=%b, want q=0 ovf=0 udf=0", q, ovf, udf);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tc_en0: got %b want 0", tc);
        end
        en = 1'b1; dir = 1'b0; #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tc_down_at_zero: got %b want 1", tc);
        end
        dir = 1'b1; #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tc_up_at_zero: got %b want 0", tc);
        end
        checks++;
        if ({q1, q0} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL cascade_reset: got %0d want 0", {q1, q0});
        end
        reset = 1'b0; cReset = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [2:0] expQ [14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
        logic       expO [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        logic       expT [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        en = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({q, ovf, udf, tc} !== {expQ[i], expO[i], 1'b0, expT[i]}) begin
                errors++;
                $display("[TB] FAIL wrap_up[%0d]: got q=%0d ovf=%b udf=%b tc=%b, want q=%0d ovf=%b udf=0 tc=%b",
                         i, q, ovf, udf, tc, expQ[i], expO[i], expT[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [2:0] expQ [5] = '{1, 0, 5, 4, 3};
        logic       expU [5] = '{0, 0, 1, 0, 0};
        logic       expT [5] = '{0, 1, 0, 0, 0};
        dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({q, ovf, udf, tc} !== {expQ[i], 1'b0, expU[i], expT[i]}) begin
                errors++;
                $display("[TB] FAIL wrap_down[%0d]: got q=%0d ovf=%b udf=%b tc=%b, want q=%0d ovf=0 udf=%b tc=%b",
                         i, q, ovf, udf, tc, expQ[i], expU[i], expT[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [2:0] expQ [13] = '{4, 5, 5, 5, 5, 5, 4, 3, 2, 1, 0, 0, 0};
        logic       expT [13] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        mode = 1'b1; dir = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 6) dir = 1'b0;
            tick();
            checks++;
            if ({q, ovf, udf, tc} !== {expQ[i], 1'b0, 1'b0, expT[i]}) begin
                errors++;
                $display("[TB] FAIL saturate[%0d]: got q=%0d ovf=%b udf=%b tc=%b, want q=%0d ovf=0 udf=0 tc=%b",
                         i, q, ovf, udf, tc, expQ[i], expT[i]);
            end
        end
    endtask

    task automatic test_load();
        // Each row: en, dir, clr, load, loadVal -> expected q, ovf
        logic [2:0] rowLv [8] = '{7, 3, 3, 0, 5, 0, 4, 0};
        logic       rowEn [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
        logic       rowCl [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
        logic       rowLd [8] = '{1, 1, 1, 0, 1, 0, 1, 0};
        logic [2:0] expQ  [8] = '{5, 0, 3, 0, 5, 0, 4, 4};
        logic       expO  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        mode = 1'b0; dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = rowEn[i]; clr = rowCl[i]; load = rowLd[i]; loadVal = rowLv[i];
            tick();
            checks++;
            if ({q, ovf, udf} !== {expQ[i], expO[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL load[%0d]: got q=%0d ovf=%b udf=%b, want q=%0d ovf=%b udf=0",
                         i, q, ovf, udf, expQ[i], expO[i]);
            end
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_tc_en0: got %b want 0", tc);
        end
        clr = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset_midcount();
        logic [2:0] expQ [3] = '{1, 2, 3};
        en = 1'b1; dir = 1'b1; load = 1'b1; loadVal = 3'd2; reset = 1'b1;
        tick();
        checks++;
        if ({q, ovf, udf} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_midcount: got q=%0d ovf=%b udf=%b, want q=0 ovf=0 udf=0", q, ovf, udf);
        end
        reset = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL resume[%0d]: got q=%0d want %0d", i, q, expQ[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] expQ [7] = '{4, 5, 0, 1, 0, 5, 4};
        logic       expO [7] = '{0, 0, 1, 0, 0, 0, 0};
        logic       expU [7] = '{0, 0, 0, 0, 0, 1, 0};
        en = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) dir = 1'b0;
            tick();
            checks++;
            if ({q, ovf, udf} !== {expQ[i], expO[i], expU[i]}) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got q=%0d ovf=%b udf=%b, want q=%0d ovf=%b udf=%b",
                         i, q, ovf, udf, expQ[i], expO[i], expU[i]);
            end
        end
    endtask

    task automatic test_cascade();
        logic [5:0] expCount;
        cEn = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            expCount = 6'(k);
            checks++;
            if ({q1, q0, tc0, tc1, ovf0, ovf1} !==
                {expCount, expCount[2:0] == 3'd7, expCount == 6'd63,
                 expCount[2:0] == 3'd0, k == 64}) begin
                errors++;
                $display("[TB] FAIL cascade[%0d]: got q=%0o tc0=%b tc1=%b ovf0=%b ovf1=%b, want q=%0o",
                         k, {q1, q0}, tc0, tc1, ovf0, ovf1, expCount);
            end
        end
        cEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_reset_midcount();
        test_back_to_back();
        test_cascade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
